// File: rtl/serial_subtractor_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM encoding, default width
// and the bit-counter sizing rule.
package serial_subtractor_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_e;

    localparam int DEFAULT_WIDTH = 8;

    function automatic int cnt_width(input int width);
        return $clog2(width);
    endfunction

endpackage

// File: rtl/serial_subtractor_if.sv
// Start/busy/done handshake plus operand and result bus of the serial subtractor.
interface serial_subtractor_if
    import serial_subtractor_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
);
    logic             start;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] DIFF;
    logic             BORROW;

    modport master (
        output start, A, B,
        input  busy, done, DIFF, BORROW
    );

    modport slave (
        input  start, A, B,
        output busy, done, DIFF, BORROW
    );
endinterface

// File: rtl/serial_subtractor_half_subtractor.sv
// Gate-level half subtractor: D = X ^ Y, Bo = ~X & Y.
module half_subtractor (
    input  wire X,
    input  wire Y,
    output wire D,
    output wire Bo
);
    wire w_nx;

    xor u_xor (D, X, Y);
    not u_not (w_nx, X);
    and u_and (Bo, w_nx, Y);
endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial A - B, LSB first, one bit per clock with a registered borrow.
// Result and final borrow are published only on the last RUN edge.
module serial_subtractor
    import serial_subtractor_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic                clk,
    input  logic                rst_n,
    serial_subtractor_if.slave  bus
);
    localparam int CW = cnt_width(WIDTH);

    state_e           r_state;
    state_e           w_next;
    logic [WIDTH-1:0] r_sa;
    logic [WIDTH-1:0] r_sb;
    logic [WIDTH-1:0] r_res;
    logic [WIDTH-1:0] r_diff;
    logic             r_borrow;
    logic             r_br;
    logic [CW-1:0]    r_cnt;
    logic             r_busy;
    logic             r_done;
    logic             w_last;

    wire w_d1;
    wire w_bo1;
    wire w_bo2;
    wire w_d;
    wire w_br_next;

    // Full-subtractor cell: two half subtractors plus an OR for the borrow.
    half_subtractor u_hs0 (.X(r_sa[0]), .Y(r_sb[0]), .D(w_d1), .Bo(w_bo1));
    half_subtractor u_hs1 (.X(w_d1),    .Y(r_br),    .D(w_d),  .Bo(w_bo2));
    or u_or (w_br_next, w_bo1, w_bo2);

    assign w_last = (r_cnt == CW'(WIDTH - 1));

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic; start is only honoured in IDLE.
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (bus.start) begin
                    w_next = RUN;
                end else begin
                    w_next = IDLE;
                end
            end
            RUN: begin
                if (w_last) begin
                    w_next = DONE;
                end else begin
                    w_next = RUN;
                end
            end
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Handshake flags registered from the next state so they align with it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_busy <= 1'b0;
            r_done <= 1'b0;
        end else begin
            r_busy <= (w_next == RUN);
            r_done <= (w_next == DONE);
        end
    end

    // Operand/result shifting, borrow flop, bit counter and result capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sa     <= '0;
            r_sb     <= '0;
            r_res    <= '0;
            r_diff   <= '0;
            r_borrow <= 1'b0;
            r_br     <= 1'b0;
            r_cnt    <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.start) begin
                        r_sa  <= bus.A;
                        r_sb  <= bus.B;
                        r_res <= '0;
                        r_br  <= 1'b0;
                        r_cnt <= '0;
                    end
                end
                RUN: begin
                    r_res <= {w_d, r_res[WIDTH-1:1]};
                    r_sa  <= r_sa >> 1;
                    r_sb  <= r_sb >> 1;
                    r_br  <= w_br_next;
                    r_cnt <= r_cnt + CW'(1);
                    if (w_last) begin
                        r_diff   <= {w_d, r_res[WIDTH-1:1]};
                        r_borrow <= w_br_next;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.busy   = r_busy;
    assign bus.done   = r_done;
    assign bus.DIFF   = r_diff;
    assign bus.BORROW = r_borrow;
endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
- Bit-serial WIDTH-bit subtractor: computes DIFF = A - B, one bit per clock, LSB first, with a registered borrow flip-flop.
- Datapath cell is built from gate-level half-subtractor instances, in the same style as the team's gate-level adder cells.
- This is the subtract direction of the team's adder arithmetic.
- Start/busy/done handshake to a controlling FSM or testbench.

Parameters:
- WIDTH, 8, operand and result width in bits; legal range >= 2.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- rst_n  input  1  reset, asynchronous assert, active-low.
- start  input  1  request; sampled only in IDLE.
- A  input  WIDTH  minuend; captured on the accepting edge.
- B  input  WIDTH  subtrahend; captured on the accepting edge.
- busy  output  1  high while in RUN.
- done  output  1  one-cycle pulse, high in the DONE state.
- DIFF  output  WIDTH  result, (A - B) mod 2^WIDTH.
- BORROW  output  1  final borrow out: 1 iff A < B unsigned.

Behaviour:
- Clocking and reset:
  - Single clock domain.
  - One FSM with states IDLE, RUN, DONE.
  - rst_n low, at any time including mid-RUN, immediately forces IDLE and clears all registers.
  - Reset values: busy=0, done=0, DIFF=0, BORROW=0, bit counter=0, borrow flop=0, shift registers=0.
  - No partial result survives a reset.
- IDLE:
  - On an edge with start=1: load A and B into shift registers SA and SB, borrow flop=0, counter=0, go to RUN.
  - start=0: stay in IDLE.
  - DIFF and BORROW hold the previous result.
- RUN (busy=1), each edge:
  - d = SA[0] ^ SB[0] ^ br.
  - br_next = (~SA[0] & SB[0]) | (~(SA[0] ^ SB[0]) & br).
  - Implement d and br_next as two half-subtractor instances plus one OR gate.
  - Shift d into the MSB of the result shift register; shift SA and SB right by 1; counter++.
  - On the edge where counter == WIDTH-1, the last bit is processed: transfer the result register to DIFF, br_next to BORROW, go to DONE.
- DONE:
  - done=1 and busy=0 for exactly one cycle.
  - Next edge returns to IDLE unconditionally.
- Latency:
  - start sampled at edge E0.
  - Bits processed at edges E1..E_WIDTH.
  - done high during the cycle after E_WIDTH.
  - Earliest next accept is edge E_WIDTH+2.
- start asserted in RUN or DONE is ignored; it is not queued.
- A and B may change freely after the accepting edge.
- DIFF and BORROW update only on the final RUN edge.
  - They are stable and valid from the cycle in which done is high until the next completion.
  - They are not cleared by a new start.
- Wrap-around:
  - Result is modulo 2^WIDTH.
  - BORROW=1 indicates underflow.
  - Equal operands give DIFF=0, BORROW=0.
- busy and done are never high simultaneously.

Decomposition:
- Shared package contains:
  - FSM state encoding constants: IDLE=2'b00, RUN=2'b01, DONE=2'b10.
  - Default WIDTH constant.
  - Counter width rule: clog2(WIDTH).
- Sub-module half_subtractor: gate-level, ports X, Y, D, Bo.
  - D = X xor Y.
  - Bo = (not X) and Y.
  - Instantiated twice, with an OR gate forming the full-subtractor borrow.

Test Plan:
- Reset: assert rst_n=0 mid-RUN of 8'hAA-8'h55 -> busy=0, done=0, DIFF=0, BORROW=0 immediately. After release, idle with no done pulse.
- Basic: A=10, B=3, start at E0 -> done high in the cycle after E8 only; DIFF=8'd7, BORROW=0; busy high exactly 8 cycles.
- Underflow: A=3, B=10 -> DIFF=8'hF9, BORROW=1. Also A=0, B=1 -> DIFF=8'hFF, BORROW=1.
- Boundaries: A=B=8'hFF -> DIFF=0, BORROW=0. A=8'h80, B=8'h01 -> DIFF=8'h7F, BORROW=0 (full borrow ripple).
- Ignored start: hold start=1 continuously with A=20, B=5 -> DIFF=15 after the first op. Next accept occurs at E10, not during RUN or DONE; A changed during RUN does not affect the result.
- Random: 1000 random A, B with back-to-back starts -> DIFF == (A-B) mod 256 and BORROW == (A<B) on every done pulse; busy and done never both 1.
